// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for an in-order pipeline that has no forwarding.
// It tracks the destinations of instructions in EX..WB and stalls ID on a source match.
module hazard_scoreboard #(
  parameter int DEPTH     = 3,
  parameter int REG_BITS  = 3,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                flush,
  input  logic [REG_BITS-1:0] Rs,
  input  logic                RsV,
  input  logic [REG_BITS-1:0] Rt,
  input  logic                RtV,
  input  logic [REG_BITS-1:0] Rd,
  input  logic                RdV,
  output logic                stall,
  output logic [REG_BITS-1:0] ex_dest,
  output logic                ex_dest_v,
  output logic [CNT_W-1:0]    stall_cnt
);

  // The regfile writes before it reads, so the WB entry is excluded from the compare when bypassing.
  localparam int NCMP = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  logic [DEPTH-1:0]    sb_v_q;
  logic [REG_BITS-1:0] sb_r_q [DEPTH];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                entry0_v_d;
  logic                hit_s, hit_t;

  always_comb begin
    hit_s = 1'b0;
    hit_t = 1'b0;
    for (int i = 0; i < NCMP; i++) begin
      if (sb_v_q[i] && (sb_r_q[i] == Rs)) hit_s = 1'b1;
      if (sb_v_q[i] && (sb_r_q[i] == Rt)) hit_t = 1'b1;
    end
    hit_s = hit_s & RsV;
    hit_t = hit_t & RtV;
  end

  assign stall = id_valid & ~flush & (hit_s | hit_t);

  always_comb begin
    entry0_v_d = id_valid & RdV & ~stall & ~flush;
    cnt_d      = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v_q <= '0;
      for (int i = 0; i < DEPTH; i++) sb_r_q[i] <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        sb_v_q[i] <= sb_v_q[i-1];
        sb_r_q[i] <= sb_r_q[i-1];
      end
      // Entry 0 register ID is loaded even for bubbles; only the valid bit matters.
      sb_v_q[0] <= entry0_v_d;
      sb_r_q[0] <= Rd;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_dest   = sb_r_q[0];
  assign ex_dest_v = sb_v_q[0];
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (bypass, no bypass, 2-bit counter) share one stimulus stream.
// A ready-time register model is checked on every cycle, and directed literals pin that model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst, id_valid, flush, RsV, RtV, RdV;
  logic [2:0] Rs, Rt, Rd;

  logic        stall_w [3];
  logic [2:0]  exd_w   [3];
  logic        exv_w   [3];
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;
  logic [31:0] cnt_w   [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .REG_BITS(3), .WB_BYPASS(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
    .Rs(Rs), .RsV(RsV), .Rt(Rt), .RtV(RtV), .Rd(Rd), .RdV(RdV),
    .stall(stall_w[0]), .ex_dest(exd_w[0]), .ex_dest_v(exv_w[0]), .stall_cnt(cnt_a));

  hazard_scoreboard #(.DEPTH(3), .REG_BITS(3), .WB_BYPASS(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
    .Rs(Rs), .RsV(RsV), .Rt(Rt), .RtV(RtV), .Rd(Rd), .RdV(RdV),
    .stall(stall_w[1]), .ex_dest(exd_w[1]), .ex_dest_v(exv_w[1]), .stall_cnt(cnt_b));

  hazard_scoreboard #(.DEPTH(3), .REG_BITS(3), .WB_BYPASS(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
    .Rs(Rs), .RsV(RsV), .Rt(Rt), .RtV(RtV), .Rd(Rd), .RdV(RdV),
    .stall(stall_w[2]), .ex_dest(exd_w[2]), .ex_dest_v(exv_w[2]), .stall_cnt(cnt_c));

  assign cnt_w[0] = {16'd0, cnt_a};
  assign cnt_w[1] = {16'd0, cnt_b};
  assign cnt_w[2] = {30'd0, cnt_c};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a register written by an instruction accepted in cycle c may be read
  // without a stall from cycle c + 1 + (number of compared stages).
  int          win  [3] = '{2, 3, 2};
  int          cmax [3] = '{65535, 65535, 3};
  int          ready [3][8];
  int          m_cnt [3];
  logic [2:0]  m_exd [3];
  logic        m_exv [3];
  bit          known = 0;
  int          t = 1;

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic hz, es;
        hz = (RsV && (t < ready[k][Rs])) || (RtV && (t < ready[k][Rt]));
        es = id_valid && !flush && hz;
        if (known) begin
          chk($sformatf("stall[%0d]", k), 32'(stall_w[k]), 32'(es));
          chk($sformatf("ex_dest[%0d]", k), 32'(exd_w[k]), 32'(m_exd[k]));
          chk($sformatf("ex_dest_v[%0d]", k), 32'(exv_w[k]), 32'(m_exv[k]));
          chk($sformatf("stall_cnt[%0d]", k), cnt_w[k], 32'(m_cnt[k]));
        end
        if (rst) begin
          for (int r = 0; r < 8; r++) ready[k][r] = 0;
          m_cnt[k] = 0;
          m_exd[k] = 3'd0;
          m_exv[k] = 1'b0;
        end else begin
          if (es && (m_cnt[k] < cmax[k])) m_cnt[k]++;
          m_exv[k] = id_valid && RdV && !es && !flush;
          m_exd[k] = Rd;
          if (m_exv[k]) ready[k][Rd] = t + 1 + win[k];
        end
      end
      if (rst) known = 1;
      t++;
    end
  end

  task automatic drv(input logic r, input logic v, input logic f,
                     input logic [2:0] rs, input logic rsv,
                     input logic [2:0] rt, input logic rtv,
                     input logic [2:0] rd, input logic rdv);
    @(posedge clk); #1;
    rst = r; id_valid = v; flush = f;
    Rs = rs; RsV = rsv; Rt = rt; RtV = rtv; Rd = rd; RdV = rdv;
    @(negedge clk); #1;
  endtask

  task automatic ins(input logic [2:0] rs, input logic rsv, input logic [2:0] rt,
                     input logic rtv, input logic [2:0] rd, input logic rdv);
    drv(1'b0, 1'b1, 1'b0, rs, rsv, rt, rtv, rd, rdv);
  endtask

  task automatic wr(input logic [2:0] rd);
    ins(3'd0, 1'b0, 3'd0, 1'b0, rd, 1'b1);
  endtask

  task automatic bub();
    drv(1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1);
  endtask

  task automatic do_reset();
    drv(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
    Rs = 3'd0; RsV = 1'b0; Rt = 3'd0; RtV = 1'b0; Rd = 3'd0; RdV = 1'b0;
    do_reset();
    do_reset();

    // back-to-back dependence on r3
    wr(3'd3);
    chk("reset_stall", 32'(stall_w[0]), 32'd0);
    chk("reset_cnt", cnt_w[0], 32'd0);
    for (int i = 0; i < 4; i++) begin
      ins(3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1);
      chk("t1_stall_byp", 32'(stall_w[0]), (i < 2) ? 32'd1 : 32'd0);
      chk("t1_stall_nobyp", 32'(stall_w[1]), (i < 3) ? 32'd1 : 32'd0);
    end
    bub();
    chk("t1_stall_bubble", 32'(stall_w[0]), 32'd0);
    chk("t1_cnt_byp", cnt_w[0], 32'd2);
    chk("t1_cnt_nobyp", cnt_w[1], 32'd3);
    chk("t1_ex_dest", 32'(exd_w[0]), 32'd4);
    chk("t1_ex_dest_v", 32'(exv_w[0]), 32'd1);
    do_reset();
    chk("t1_bubble_no_entry", 32'(exv_w[0]), 32'd0);

    // one independent instruction in between
    wr(3'd3);
    ins(3'd1, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1);
    chk("t2_indep", 32'(stall_w[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ins(3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("t2_stall_byp", 32'(stall_w[0]), (i < 1) ? 32'd1 : 32'd0);
      chk("t2_stall_nobyp", 32'(stall_w[1]), (i < 2) ? 32'd1 : 32'd0);
    end
    do_reset();

    // r0 is a real register
    wr(3'd0);
    ins(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0);
    chk("t3_r0_rtv0", 32'(stall_w[0]), 32'd0);
    ins(3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0);
    chk("t3_r0_rtv1", 32'(stall_w[0]), 32'd1);
    do_reset();

    // self-dependence, then flush beats a hit
    ins(3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1);
    chk("t4_self", 32'(stall_w[0]), 32'd0);
    wr(3'd2);
    drv(1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1);
    chk("t4_flush_stall", 32'(stall_w[0]), 32'd0);
    bub();
    chk("t4_flush_bubble", 32'(exv_w[0]), 32'd0);
    chk("t4_flush_cnt", cnt_w[0], 32'd0);
    do_reset();

    // two writes to r5, reader uses r5 on both sources
    wr(3'd5);
    wr(3'd5);
    for (int i = 0; i < 4; i++) begin
      ins(3'd5, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0);
      chk("t5_stall_byp", 32'(stall_w[0]), (i < 2) ? 32'd1 : 32'd0);
      chk("t5_stall_nobyp", 32'(stall_w[1]), (i < 3) ? 32'd1 : 32'd0);
    end
    bub();
    chk("t5_cnt_single", cnt_w[0], 32'd2);
    do_reset();

    // reset during a stall
    wr(3'd3);
    ins(3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("t6_stall_before", 32'(stall_w[0]), 32'd1);
    drv(1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("t6_stall_in_rst", 32'(stall_w[0]), 32'd1);
    ins(3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("t6_stall_after", 32'(stall_w[0]), 32'd0);
    chk("t6_exv_after", 32'(exv_w[0]), 32'd0);
    chk("t6_cnt_after", cnt_w[0], 32'd0);

    // counter saturation on the 2-bit instance
    for (int p = 0; p < 3; p++) begin
      wr(3'd1);
      for (int i = 0; i < 3; i++) ins(3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    end
    bub();
    chk("t7_cnt_byp", cnt_w[0], 32'd6);
    chk("t7_cnt_nobyp", cnt_w[1], 32'd9);
    chk("t7_cnt_sat", cnt_w[2], 32'd3);
    wr(3'd1);
    ins(3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    ins(3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    bub();
    chk("t7_cnt_sat_hold", cnt_w[2], 32'd3);
    chk("t7_cnt_byp2", cnt_w[0], 32'd8);

    bub();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
